// File: rtl/t16_pkg.sv
// Shared definitions for the T16 multi-cycle core: opcodes, FSM states and instruction field offsets.
package t16_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_ADDI = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_BEQ  = 4'd7;
    localparam logic [3:0] OP_HALT = 4'd8;

    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;
    localparam int IMM_W   = 6;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_WB    = 3'd3,
        S_HALT  = 3'd4
    } state_t;

endpackage

// File: rtl/t16_mc_core_if.sv
// Instruction and data memory req/ack ports of the T16 core; master is the core, slave the memories.
interface t16_mc_core_if #(
    parameter int DW = 16,
    parameter int PW = 5
);
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          imem_ack;
    logic [15:0]   imem_rdata;
    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_ack;
    logic [DW-1:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/t16_regfile.sv
// 8 x DW register file: two asynchronous read ports, one synchronous write port, r0 hard-wired to zero.
module t16_regfile #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [2:0]    waddr,
    input  logic [DW-1:0] wdata,
    input  logic [2:0]    raddr_a,
    input  logic [2:0]    raddr_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b
);
    logic [DW-1:0] regs [8];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (we && (waddr != 3'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 3'd0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == 3'd0) ? '0 : regs[raddr_b];
endmodule

// File: rtl/t16_mc_core.sv
// T16 multi-cycle core: FETCH/EXEC/MEM/WB/HALT sequencing over req/ack instruction and data ports.
module t16_mc_core
    import t16_pkg::*;
#(
    parameter int            DW       = 16,
    parameter int            PW       = 5,
    parameter logic [PW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    t16_mc_core_if.master bus,
    output logic          halted,
    output logic [PW-1:0] pc_out
);
    state_t               state, state_nxt;
    logic [PW-1:0]        pc, pc_inc, pc_exec;
    logic [15:0]          ir;
    logic [3:0]           op;
    logic [2:0]           rd, rs1, rs2, raddr_b;
    logic [DW-1:0]        rdata_a, rdata_b;
    logic signed [DW-1:0] imm, opa, opb, alu_res;
    logic signed [DW-1:0] res_p1, sdata_p1;
    logic                 taken, is_nop, rf_we;

    function automatic logic signed [DW-1:0] sext_imm(input logic [IMM_W-1:0] v);
        return {{(DW-IMM_W){v[IMM_W-1]}}, v};
    endfunction

    // LW/SW/ADDI all share the rs1+imm path, so it doubles as the default.
    function automatic logic signed [DW-1:0] alu(input logic [3:0] f,
                                                 input logic signed [DW-1:0] x,
                                                 input logic signed [DW-1:0] y,
                                                 input logic signed [DW-1:0] k);
        case (f)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            default: return x + k;
        endcase
    endfunction

    assign op  = ir[OP_LSB +: 4];
    assign rd  = ir[RD_LSB +: 3];
    assign rs1 = ir[RS1_LSB +: 3];
    assign rs2 = ir[RS2_LSB +: 3];
    assign imm = sext_imm(ir[IMM_W-1:0]);

    // Port B reads rs2 for register-register ops, otherwise rd (store data / BEQ operand).
    assign raddr_b = (op < OP_ADDI) ? rs2 : rd;
    assign rf_we   = (state == S_WB);

    t16_regfile #(.DW(DW)) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we),
        .waddr   (rd),
        .wdata   (res_p1),
        .raddr_a (rs1),
        .raddr_b (raddr_b),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    assign opa     = rdata_a;
    assign opb     = rdata_b;
    assign alu_res = alu(op, opa, opb, imm);
    assign is_nop  = (op > OP_HALT);
    assign taken   = (op == OP_BEQ) && (opa == opb);
    assign pc_inc  = pc + PW'(1);
    assign pc_exec = taken ? (pc_inc + imm[PW-1:0]) : pc_inc;

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: if (bus.imem_ack) state_nxt = S_EXEC;
            S_EXEC: begin
                if (op == OP_LW || op == OP_SW) state_nxt = S_MEM;
                else if (op <= OP_ADDI)         state_nxt = S_WB;
                else if (op == OP_HALT)         state_nxt = S_HALT;
                else                            state_nxt = S_FETCH;
            end
            S_MEM:   if (bus.dmem_ack) state_nxt = (op == OP_LW) ? S_WB : S_FETCH;
            S_WB:    state_nxt = S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        bus.imem_req   = 1'b0;
        bus.dmem_req   = 1'b0;
        bus.imem_addr  = pc;
        bus.dmem_we    = (op == OP_SW);
        bus.dmem_addr  = res_p1;
        bus.dmem_wdata = sdata_p1;
        halted         = (state == S_HALT);
        pc_out         = pc;
        if (!rst) begin
            bus.imem_req = (state == S_FETCH);
            bus.dmem_req = (state == S_MEM);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            ir <= '0;
        end else begin
            case (state)
                S_FETCH: if (bus.imem_ack) ir <= bus.imem_rdata;
                S_EXEC:  if (op == OP_BEQ || is_nop) pc <= pc_exec;
                S_MEM:   if (bus.dmem_ack && op == OP_SW) pc <= pc_inc;
                S_WB:    pc <= pc_inc;
                default: ;
            endcase
        end
    end

    // EXEC -> MEM/WB boundary: result or effective address, store data; load data replaces the result.
    always_ff @(posedge clk) begin
        if (state == S_EXEC) begin
            res_p1   <= alu_res;
            sdata_p1 <= opb;
        end else if (state == S_MEM && bus.dmem_ack && op == OP_LW) begin
            res_p1 <= bus.dmem_rdata;
        end
    end
endmodule
